// File: rtl/li_ram_reader.sv
// Burst read initiator for the latency-insensitive RAM: turns (addr, len) commands into
// in-order read requests and forwards the responses as a valid/ready stream with a last marker.
module li_ram_reader #(
    parameter int ADDR_WIDTH      = 8,
    parameter int DATA_WIDTH      = 16,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] cmd_addr_in,
    input  logic [ADDR_WIDTH:0]   cmd_len_in,
    input  logic                  cmd_valid_in,
    output logic                  cmd_ready_out,
    output logic [ADDR_WIDTH-1:0] rd_req_addr_out,
    output logic                  rd_req_valid_out,
    input  logic                  rd_req_ready_in,
    input  logic [DATA_WIDTH-1:0] rd_resp_data_in,
    input  logic                  rd_resp_valid_in,
    output logic                  rd_resp_ready_out,
    output logic [DATA_WIDTH-1:0] out_data_out,
    output logic                  out_last_out,
    output logic                  out_valid_out,
    input  logic                  out_ready_in,
    output logic                  busy_out,
    output logic                  done_out
);

    localparam int OC_W  = $clog2(MAX_OUTSTANDING + 1);
    localparam int LEN_W = ADDR_WIDTH + 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                state_reg, state_next;
    logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
    logic [LEN_W-1:0]      req_left_reg, req_left_next;
    logic [LEN_W-1:0]      resp_left_reg, resp_left_next;
    logic [OC_W-1:0]       outstanding_reg, outstanding_next;
    logic                  done_reg, done_next;

    logic run;
    logic cmd_fire;
    logic req_fire;
    logic resp_fire;

    assign run      = (state_reg == RUN);
    assign cmd_fire = cmd_valid_in && !run;

    // Request issue stalls once MAX_OUTSTANDING reads are in flight, so output
    // backpressure propagates to the RAM instead of dropping returned data.
    assign rd_req_valid_out = run && (req_left_reg != '0)
                              && (outstanding_reg < OC_W'(MAX_OUTSTANDING));
    assign rd_req_addr_out  = addr_reg;
    assign req_fire         = rd_req_valid_out && rd_req_ready_in;

    // Response path is pure wiring gated by RUN; no register is added.
    assign out_valid_out     = run && rd_resp_valid_in;
    assign out_data_out      = rd_resp_data_in;
    assign rd_resp_ready_out = run && out_ready_in;
    assign out_last_out      = run && (resp_left_reg == LEN_W'(1));
    assign resp_fire         = rd_resp_valid_in && rd_resp_ready_out;

    assign cmd_ready_out = !run;
    assign busy_out      = run;
    assign done_out      = done_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= IDLE;
            addr_reg        <= '0;
            req_left_reg    <= '0;
            resp_left_reg   <= '0;
            outstanding_reg <= '0;
            done_reg        <= 1'b0;
        end else begin
            state_reg       <= state_next;
            addr_reg        <= addr_next;
            req_left_reg    <= req_left_next;
            resp_left_reg   <= resp_left_next;
            outstanding_reg <= outstanding_next;
            done_reg        <= done_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        addr_next        = addr_reg;
        req_left_next    = req_left_reg;
        resp_left_next   = resp_left_reg;
        outstanding_next = outstanding_reg;
        done_next        = 1'b0;

        case (state_reg)
            IDLE: begin
                if (cmd_fire) begin
                    if (cmd_len_in == '0) begin
                        done_next = 1'b1;
                    end else begin
                        addr_next        = cmd_addr_in;
                        req_left_next    = cmd_len_in;
                        resp_left_next   = cmd_len_in;
                        outstanding_next = '0;
                        state_next       = RUN;
                    end
                end
            end
            RUN: begin
                if (req_fire) begin
                    addr_next     = addr_reg + ADDR_WIDTH'(1);
                    req_left_next = req_left_reg - LEN_W'(1);
                end
                outstanding_next = outstanding_reg + OC_W'(req_fire) - OC_W'(resp_fire);
                if (resp_fire) begin
                    resp_left_next = resp_left_reg - LEN_W'(1);
                    if (resp_left_reg == LEN_W'(1)) begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_li_ram_reader.sv
// Bench for li_ram_reader: a behavioural order-preserving RAM with random ready/latency,
// a per-cycle monitor, and a burst-level reference model (RAM[a] = 3*a).
module tb_li_ram_reader;

    localparam int AW = 8;
    localparam int DW = 16;
    localparam int MO = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] cmd_addr_in = '0;
    logic [AW:0]   cmd_len_in = '0;
    logic          cmd_valid_in = 1'b0;
    logic          cmd_ready_out;
    logic [AW-1:0] rd_req_addr_out;
    logic          rd_req_valid_out;
    logic          rd_req_ready_in;
    logic [DW-1:0] rd_resp_data_in;
    logic          rd_resp_valid_in;
    logic          rd_resp_ready_out;
    logic [DW-1:0] out_data_out;
    logic          out_last_out;
    logic          out_valid_out;
    logic          out_ready_in = 1'b0;
    logic          busy_out;
    logic          done_out;

    always #5 clk = ~clk;

    li_ram_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MO)) dut (
        .clk(clk), .rst(rst),
        .cmd_addr_in(cmd_addr_in), .cmd_len_in(cmd_len_in),
        .cmd_valid_in(cmd_valid_in), .cmd_ready_out(cmd_ready_out),
        .rd_req_addr_out(rd_req_addr_out), .rd_req_valid_out(rd_req_valid_out),
        .rd_req_ready_in(rd_req_ready_in),
        .rd_resp_data_in(rd_resp_data_in), .rd_resp_valid_in(rd_resp_valid_in),
        .rd_resp_ready_out(rd_resp_ready_out),
        .out_data_out(out_data_out), .out_last_out(out_last_out),
        .out_valid_out(out_valid_out), .out_ready_in(out_ready_in),
        .busy_out(busy_out), .done_out(done_out)
    );

    typedef struct {
        logic [DW-1:0] data;
        int            due;
    } resp_t;

    resp_t         ram_q[$];
    bit            ram_random = 1'b0;
    int            cyc = 0;
    logic [DW-1:0] cap_data[$];
    logic          cap_last[$];
    logic [AW-1:0] cap_addr[$];
    int            fire_cyc[$], req_cyc[$], cmd_cyc[$], done_cyc[$];
    logic          done_busy[$];
    int            outst = 0, max_outst = 0, full_viol = 0, idle_viol = 0;
    logic [DW-1:0] exp_data[$];
    logic          exp_last[$];
    logic [AW-1:0] exp_addr[$];
    int            compared = 0, mismatched = 0;
    bit            timed_out = 1'b0;

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        return DW'(3 * int'(a));
    endfunction

    // Monitor samples at negedge; the RAM model updates just after posedge.
    initial begin
        bit            req_s, resp_s, rst_s;
        logic [AW-1:0] addr_s;
        resp_t         e;
        rd_req_ready_in  = 1'b0;
        rd_resp_valid_in = 1'b0;
        rd_resp_data_in  = '0;
        forever begin
            @(negedge clk);
            cyc++;
            rst_s  = rst;
            req_s  = rd_req_valid_out && rd_req_ready_in;
            resp_s = rd_resp_valid_in && rd_resp_ready_out;
            addr_s = rd_req_addr_out;
            if (rst) begin
                outst = 0;
            end else begin
                if (cmd_valid_in && cmd_ready_out) cmd_cyc.push_back(cyc);
                if (done_out) begin
                    done_cyc.push_back(cyc);
                    done_busy.push_back(busy_out);
                end
                if (outst >= MO && rd_req_valid_out) full_viol++;
                if (!busy_out && (rd_req_valid_out || out_valid_out || rd_resp_ready_out || out_last_out))
                    idle_viol++;
                if (req_s) begin
                    cap_addr.push_back(addr_s);
                    req_cyc.push_back(cyc);
                end
                if (out_valid_out && out_ready_in) begin
                    cap_data.push_back(out_data_out);
                    cap_last.push_back(out_last_out);
                    fire_cyc.push_back(cyc);
                end
                outst = outst + int'(req_s) - int'(resp_s);
                if (outst > max_outst) max_outst = outst;
            end
            @(posedge clk);
            #1;
            if (rst_s) begin
                ram_q.delete();
            end else begin
                if (resp_s && ram_q.size() > 0) ram_q.delete(0);
                if (req_s) begin
                    e.data = mem_word(addr_s);
                    e.due  = cyc + (ram_random ? int'($urandom_range(1, 3)) : 1);
                    ram_q.push_back(e);
                end
            end
            rd_req_ready_in = ram_random ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (ram_q.size() > 0 && ram_q[0].due <= cyc + 1) begin
                rd_resp_valid_in = 1'b1;
                rd_resp_data_in  = ram_q[0].data;
            end else begin
                rd_resp_valid_in = 1'b0;
                rd_resp_data_in  = DW'($urandom);
            end
        end
    end

    task automatic clear_caps();
        cap_data.delete(); cap_last.delete(); cap_addr.delete();
        fire_cyc.delete(); req_cyc.delete(); cmd_cyc.delete();
        done_cyc.delete(); done_busy.delete();
        exp_data.delete(); exp_last.delete(); exp_addr.delete();
        full_viol = 0; max_outst = 0; timed_out = 1'b0;
    endtask

    // Reference model: a burst reads addr, addr+1, ... modulo 2^AW; last on the final word.
    task automatic expect_burst(input logic [AW-1:0] a, input int len);
        logic [AW-1:0] ea;
        for (int i = 0; i < len; i++) begin
            ea = a + AW'(i);
            exp_addr.push_back(ea);
            exp_data.push_back(mem_word(ea));
            exp_last.push_back(i == len - 1);
        end
    endtask

    task automatic do_cmd(input logic [AW-1:0] a, input int len);
        int n;
        n = 0;
        cmd_addr_in  = a;
        cmd_len_in   = (AW + 1)'(len);
        cmd_valid_in = 1'b1;
        forever begin
            @(negedge clk);
            if (cmd_ready_out) break;
            n++;
            if (n > 3000) begin
                timed_out = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        cmd_valid_in = 1'b0;
    endtask

    // mode 0: out_ready held high, 1: toggled every cycle, 2: random.
    task automatic run_until_done(input int n, input int mode, input int limit);
        int k;
        k = 0;
        while (done_cyc.size() < n && k < limit) begin
            case (mode)
                0:       out_ready_in = 1'b1;
                1:       out_ready_in = ~out_ready_in;
                default: out_ready_in = 1'($urandom_range(0, 1));
            endcase
            @(posedge clk);
            #1;
            k++;
        end
        if (done_cyc.size() < n) timed_out = 1'b1;
        out_ready_in = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        compared++;
        if (cmd_ready_out !== 1'b1 || rd_req_valid_out !== 1'b0 || rd_resp_ready_out !== 1'b0 ||
            out_valid_out !== 1'b0 || out_last_out !== 1'b0 || busy_out !== 1'b0 ||
            done_out !== 1'b0 || rd_req_addr_out !== '0) begin
            mismatched++;
            $display("FAIL reset_outputs: got cmd_ready=%b req_valid=%b resp_ready=%b out_valid=%b last=%b busy=%b done=%b addr=%h, expected 1 0 0 0 0 0 0 00",
                     cmd_ready_out, rd_req_valid_out, rd_resp_ready_out, out_valid_out, out_last_out,
                     busy_out, done_out, rd_req_addr_out);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        compared++;
        if (cmd_ready_out !== 1'b1 || busy_out !== 1'b0 || done_out !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_release: got cmd_ready=%b busy=%b done=%b, expected 1 0 0",
                     cmd_ready_out, busy_out, done_out);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        int last;
        clear_caps();
        ram_random   = 1'b0;
        out_ready_in = 1'b1;
        expect_burst(8'h10, 4);
        do_cmd(8'h10, 4);
        run_until_done(1, 0, 100);
        compared++;
        if (timed_out || cap_data.size() != 4) begin
            mismatched++;
            $display("FAIL basic_count: got %0d words timeout=%b, expected 4 words", cap_data.size(), timed_out);
        end
        for (int i = 0; i < exp_data.size() && i < cap_data.size(); i++) begin
            compared++;
            if (cap_data[i] !== exp_data[i] || cap_last[i] !== exp_last[i] || cap_addr[i] !== exp_addr[i]) begin
                mismatched++;
                $display("FAIL basic_word[%0d]: got data=%h last=%b addr=%h, expected data=%h last=%b addr=%h",
                         i, cap_data[i], cap_last[i], cap_addr[i], exp_data[i], exp_last[i], exp_addr[i]);
            end
        end
        last = (fire_cyc.size() > 0) ? fire_cyc[fire_cyc.size() - 1] : -10;
        compared++;
        if (done_cyc.size() != 1 || done_cyc[0] != last + 1 || done_busy[0] !== 1'b0) begin
            mismatched++;
            $display("FAIL basic_done: got %0d pulses first@%0d busy=%b, expected 1 pulse @%0d busy=0",
                     done_cyc.size(), (done_cyc.size() > 0) ? done_cyc[0] : -1,
                     (done_busy.size() > 0) ? done_busy[0] : 1'bx, last + 1);
        end
        compared++;
        if (cmd_cyc.size() != 1 || req_cyc.size() != 4 || req_cyc[0] != cmd_cyc[0] + 1) begin
            mismatched++;
            $display("FAIL basic_first_req: got first request @%0d, expected @%0d",
                     (req_cyc.size() > 0) ? req_cyc[0] : -1, (cmd_cyc.size() > 0) ? cmd_cyc[0] + 1 : -1);
        end
        compared++;
        if (fire_cyc.size() != 4 || fire_cyc[0] != req_cyc[0] + 1 || fire_cyc[3] - fire_cyc[0] != 3) begin
            mismatched++;
            $display("FAIL basic_timing: got first out @%0d span %0d, expected @%0d span 3",
                     (fire_cyc.size() > 0) ? fire_cyc[0] : -1, last - ((fire_cyc.size() > 0) ? fire_cyc[0] : 0),
                     (req_cyc.size() > 0) ? req_cyc[0] + 1 : -1);
        end
        compared++;
        if (busy_out !== 1'b0 || cmd_ready_out !== 1'b1) begin
            mismatched++;
            $display("FAIL basic_idle_after: got busy=%b cmd_ready=%b, expected 0 1", busy_out, cmd_ready_out);
        end
    endtask

    task automatic test_wrap();
        clear_caps();
        ram_random = 1'b1;
        expect_burst(8'hFE, 4);
        do_cmd(8'hFE, 4);
        run_until_done(1, 0, 200);
        compared++;
        if (timed_out || cap_data.size() != 4 || cap_addr.size() != 4) begin
            mismatched++;
            $display("FAIL wrap_count: got %0d words %0d reqs timeout=%b, expected 4 4", cap_data.size(), cap_addr.size(), timed_out);
        end
        for (int i = 0; i < exp_data.size() && i < cap_data.size() && i < cap_addr.size(); i++) begin
            compared++;
            if (cap_data[i] !== exp_data[i] || cap_last[i] !== exp_last[i] || cap_addr[i] !== exp_addr[i]) begin
                mismatched++;
                $display("FAIL wrap_word[%0d]: got data=%h last=%b addr=%h, expected data=%h last=%b addr=%h",
                         i, cap_data[i], cap_last[i], cap_addr[i], exp_data[i], exp_last[i], exp_addr[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        clear_caps();
        ram_random   = 1'b1;
        out_ready_in = 1'b0;
        expect_burst(8'h00, 16);
        do_cmd(8'h00, 16);
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        run_until_done(1, 1, 500);
        compared++;
        if (timed_out || cap_data.size() != 16) begin
            mismatched++;
            $display("FAIL bp_count: got %0d words timeout=%b, expected 16", cap_data.size(), timed_out);
        end
        for (int i = 0; i < exp_data.size() && i < cap_data.size(); i++) begin
            compared++;
            if (cap_data[i] !== exp_data[i] || cap_last[i] !== exp_last[i]) begin
                mismatched++;
                $display("FAIL bp_word[%0d]: got data=%h last=%b, expected data=%h last=%b",
                         i, cap_data[i], cap_last[i], exp_data[i], exp_last[i]);
            end
        end
        compared++;
        if (max_outst != MO || full_viol != 0) begin
            mismatched++;
            $display("FAIL bp_outstanding: got max=%0d requests_while_full=%0d, expected max=%0d and 0",
                     max_outst, full_viol, MO);
        end
    endtask

    task automatic test_len_zero();
        clear_caps();
        ram_random   = 1'b0;
        out_ready_in = 1'b1;
        expect_burst(8'h05, 2);
        do_cmd(8'h33, 0);
        do_cmd(8'h05, 2);
        run_until_done(2, 0, 100);
        compared++;
        if (cmd_cyc.size() != 2 || done_cyc.size() != 2 || done_cyc[0] != cmd_cyc[0] + 1 || cmd_cyc[1] != cmd_cyc[0] + 1) begin
            mismatched++;
            $display("FAIL len0_timing: got cmds=%0d dones=%0d done0@%0d cmd1@%0d, expected both @%0d",
                     cmd_cyc.size(), done_cyc.size(), (done_cyc.size() > 0) ? done_cyc[0] : -1,
                     (cmd_cyc.size() > 1) ? cmd_cyc[1] : -1, (cmd_cyc.size() > 0) ? cmd_cyc[0] + 1 : -1);
        end
        compared++;
        if (cap_addr.size() != 2 || cap_data.size() != 2) begin
            mismatched++;
            $display("FAIL len0_no_traffic: got %0d reqs %0d words, expected 2 2", cap_addr.size(), cap_data.size());
        end
        for (int i = 0; i < exp_data.size() && i < cap_data.size(); i++) begin
            compared++;
            if (cap_data[i] !== exp_data[i] || cap_last[i] !== exp_last[i]) begin
                mismatched++;
                $display("FAIL len0_word[%0d]: got data=%h last=%b, expected data=%h last=%b",
                         i, cap_data[i], cap_last[i], exp_data[i], exp_last[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int errs;
        errs = 0;
        clear_caps();
        ram_random   = 1'b0;
        out_ready_in = 1'b1;
        expect_burst(8'h80, 256);
        expect_burst(8'h00, 2);
        do_cmd(8'h80, 256);
        do_cmd(8'h00, 2);
        run_until_done(2, 0, 100);
        compared++;
        if (timed_out || cap_data.size() != 258) begin
            mismatched++;
            $display("FAIL full_count: got %0d words timeout=%b, expected 258", cap_data.size(), timed_out);
        end
        for (int i = 0; i < exp_data.size() && i < cap_data.size(); i++) begin
            if (cap_data[i] !== exp_data[i] || cap_last[i] !== exp_last[i]) begin
                if (errs < 4)
                    $display("FAIL full_word[%0d]: got data=%h last=%b, expected data=%h last=%b",
                             i, cap_data[i], cap_last[i], exp_data[i], exp_last[i]);
                errs++;
            end
        end
        compared++;
        if (errs != 0) begin
            mismatched++;
            $display("FAIL full_stream: got %0d bad words, expected 0", errs);
        end
        compared++;
        if (cmd_cyc.size() != 2 || done_cyc.size() != 2 || cmd_cyc[1] != done_cyc[0]) begin
            mismatched++;
            $display("FAIL full_b2b: got second cmd @%0d first done @%0d, expected equal",
                     (cmd_cyc.size() > 1) ? cmd_cyc[1] : -1, (done_cyc.size() > 0) ? done_cyc[0] : -2);
        end
        compared++;
        if (fire_cyc.size() < 256 || fire_cyc[255] - fire_cyc[0] != 255) begin
            mismatched++;
            $display("FAIL full_throughput: got span %0d, expected 255",
                     (fire_cyc.size() >= 256) ? fire_cyc[255] - fire_cyc[0] : -1);
        end
    endtask

    task automatic test_reset_mid();
        int k;
        k = 0;
        clear_caps();
        ram_random   = 1'b0;
        out_ready_in = 1'b1;
        do_cmd(8'h00, 8);
        while (cap_data.size() < 3 && k < 100) begin
            @(negedge clk);
            #1;
            k++;
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        compared++;
        if (cmd_ready_out !== 1'b1 || rd_req_valid_out !== 1'b0 || rd_resp_ready_out !== 1'b0 ||
            out_valid_out !== 1'b0 || out_last_out !== 1'b0 || busy_out !== 1'b0 ||
            done_out !== 1'b0 || rd_req_addr_out !== '0) begin
            mismatched++;
            $display("FAIL midrst_outputs: got cmd_ready=%b req_valid=%b resp_ready=%b out_valid=%b last=%b busy=%b done=%b addr=%h, expected 1 0 0 0 0 0 0 00",
                     cmd_ready_out, rd_req_valid_out, rd_resp_ready_out, out_valid_out, out_last_out,
                     busy_out, done_out, rd_req_addr_out);
        end
        repeat (4) @(negedge clk);
        #1;
        compared++;
        if (cap_data.size() != 3 || done_cyc.size() != 0) begin
            mismatched++;
            $display("FAIL midrst_abandon: got %0d words %0d done pulses, expected 3 0", cap_data.size(), done_cyc.size());
        end
        @(posedge clk);
        #1;
        clear_caps();
        expect_burst(8'h20, 2);
        do_cmd(8'h20, 2);
        run_until_done(1, 0, 100);
        compared++;
        if (timed_out || cap_data.size() != 2) begin
            mismatched++;
            $display("FAIL midrst_count: got %0d words timeout=%b, expected 2", cap_data.size(), timed_out);
        end
        for (int i = 0; i < exp_data.size() && i < cap_data.size(); i++) begin
            compared++;
            if (cap_data[i] !== exp_data[i] || cap_last[i] !== exp_last[i]) begin
                mismatched++;
                $display("FAIL midrst_word[%0d]: got data=%h last=%b, expected data=%h last=%b",
                         i, cap_data[i], cap_last[i], exp_data[i], exp_last[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [AW-1:0] a;
        int            len;
        for (int r = 0; r < 6; r++) begin
            clear_caps();
            ram_random = 1'b1;
            a   = AW'($urandom);
            len = $urandom_range(1, 40);
            expect_burst(a, len);
            do_cmd(a, len);
            run_until_done(1, 2, 2000);
            compared++;
            if (timed_out || cap_data.size() != len || done_cyc.size() != 1 || full_viol != 0 || max_outst > MO) begin
                mismatched++;
                $display("FAIL rand%0d_summary: addr=%h got %0d words %0d dones viol=%0d max=%0d timeout=%b, expected %0d words 1 done 0 viol max<=%0d",
                         r, a, cap_data.size(), done_cyc.size(), full_viol, max_outst, timed_out, len, MO);
            end
            for (int i = 0; i < exp_data.size() && i < cap_data.size(); i++) begin
                compared++;
                if (cap_data[i] !== exp_data[i] || cap_last[i] !== exp_last[i]) begin
                    mismatched++;
                    $display("FAIL rand%0d_word[%0d]: got data=%h last=%b, expected data=%h last=%b",
                             r, i, cap_data[i], cap_last[i], exp_data[i], exp_last[i]);
                end
            end
        end
    endtask

    task automatic test_idle_quiet();
        compared++;
        if (idle_viol != 0) begin
            mismatched++;
            $display("FAIL idle_quiet: got %0d idle cycles with channel activity, expected 0", idle_viol);
        end
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation exceeded time limit, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_len_zero();
        test_back_to_back();
        test_reset_mid();
        test_random();
        test_idle_quiet();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/li_ram_reader.md
# li_ram_reader

Read-side initiator for the latency-insensitive RAM. It accepts a burst command (start address, length), issues read requests on the RAM's valid/ready read-request channel, and collects the read responses. The responses are forwarded in order as a valid/ready output stream with a last marker. The block caps in-flight requests so that backpressure from the output stream stalls the request side instead of losing data. It sits between a consumer (display/visualisation or stream logic) and the RAM read channels; the RAM write channel is not touched.

## Interface
- ADDR_WIDTH, 8, RAM address width.
- DATA_WIDTH, 16, RAM data width.
- MAX_OUTSTANDING, 4, maximum accepted-but-not-returned read requests (≥1).

- clk  in  1  single clock; all logic rising-edge.
- rst  in  1  reset, synchronous and active-high.
- cmd_addr_in  in  ADDR_WIDTH  burst start address.
- cmd_len_in  in  ADDR_WIDTH+1  burst length in words, 0..2^ADDR_WIDTH.
- cmd_valid_in  in  1  command valid.
- cmd_ready_out  out  1  command ready; high only in IDLE.
- rd_req_addr_out  out  ADDR_WIDTH  read address to RAM.
- rd_req_valid_out  out  1  read request valid.
- rd_req_ready_in  in  1  RAM accepts request.
- rd_resp_data_in  in  DATA_WIDTH  read data from RAM.
- rd_resp_valid_in  in  1  read data valid.
- rd_resp_ready_out  out  1  block accepts read data.
- out_data_out  out  DATA_WIDTH  stream data.
- out_last_out  out  1  high on the final word of the burst.
- out_valid_out  out  1  stream valid.
- out_ready_in  in  1  downstream accepts the word.
- busy_out  out  1  high in RUN.
- done_out  out  1  one-cycle pulse after the burst completes.

## Operation
- Handshake fires on valid && ready in the same cycle.
- Valid must not depend on ready.
- Once raised, valid and payload are held until the handshake fires.
- States are IDLE and RUN.
- IDLE:
  - cmd_ready_out=1.
  - cmd handshake with len=0: no requests are issued, done_out pulses on the next cycle, state stays IDLE.
  - cmd handshake with len>0: latch address into addr_q; req_left=len, resp_left=len, outstanding=0; go to RUN.
- RUN, request side:
  - rd_req_valid_out = (req_left≠0) && (outstanding < MAX_OUTSTANDING).
  - rd_req_addr_out = addr_q.
  - On request handshake: addr_q += 1, wrapping modulo 2^ADDR_WIDTH (0xFF→0x00 at width 8); req_left −= 1.
- RUN, response side (combinational passthrough):
  - out_valid_out = rd_resp_valid_in.
  - out_data_out = rd_resp_data_in.
  - rd_resp_ready_out = out_ready_in.
  - out_last_out = (resp_left==1).
  - On response handshake: resp_left −= 1.
- outstanding counter:
  - Width $clog2(MAX_OUTSTANDING+1).
  - Next value = outstanding + req_fire − resp_fire.
  - A request and a response firing in the same cycle leave it unchanged.
  - It never exceeds MAX_OUTSTANDING and never underflows.
- Completion: the response handshake with resp_left==1 moves the state to IDLE; done_out=1 for exactly the next cycle.
- In IDLE: rd_req_valid_out=0, out_valid_out=0, rd_resp_ready_out=0. Stray responses are not consumed.
- Responses are forwarded strictly in request order; the RAM preserves order.
- req_left and resp_left are ADDR_WIDTH+1 bits so a full-space burst (len=2^ADDR_WIDTH) is representable.

## Timing
- Reset values, from the first cycle after rst is sampled high:
  - state=IDLE, so cmd_ready_out=1.
  - rd_req_valid_out=0, rd_resp_ready_out=0, out_valid_out=0, out_last_out=0.
  - busy_out=0, done_out=0.
  - rd_req_addr_out=0, all counters 0.
- Reset mid-burst:
  - The burst is abandoned with no done_out.
  - The RAM shares rst, so no stale responses survive.
- Command to first request: rd_req_valid_out rises the cycle after the cmd handshake.
- Throughput: one word per cycle sustained when rd_req_ready_in and out_ready_in are held high.
- Output latency equals RAM latency; the block adds no register in the response path.
- done_out is registered and asserts 1 cycle after the final out handshake. cmd_ready_out is high in that same cycle, so a back-to-back command is accepted there.
- busy_out falls in the same cycle done_out rises.

## Test plan
- Preload RAM[a]=3·a via the RAM write channel; cmd addr=0x10, len=4, out_ready_in=1 → stream 0x30,0x33,0x36,0x39; last only on 0x39; done_out one pulse 1 cycle later; busy_out low afterwards.
- Wrap: cmd addr=0xFE, len=4 → requests 0xFE,0xFF,0x00,0x01 in that order; data 0x2FA,0x2FD,0x000,0x003.
- Backpressure:
  - Stimulus: cmd addr=0, len=16; hold out_ready_in=0 for 10 cycles, then toggle it every cycle.
  - Required: outstanding ≤4 at all times; rd_req_valid_out low while outstanding==4; 16 words delivered in order, none lost or duplicated.
- len=0 command → no rd_req_valid_out, no out_valid_out; done_out pulses the cycle after the handshake; next command accepted immediately.
- Full burst: cmd addr=0x80, len=256 → 256 words; out_last_out only on the word from address 0x7F; a back-to-back second command (addr=0, len=2) is accepted in the done cycle and returns RAM[0], RAM[1].
- Reset after 3 of 8 words:
  - Required: next cycle all outputs at reset values and no done_out.
  - A new cmd addr=0x20, len=2 then returns 0x60,0x63 correctly.
